// File: rtl/kgp_trace_pkg.sv
// Shared types and constants for the KGP commit trace buffer.
package kgp_trace_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  localparam int          ENTRY_W = 97;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic        taken;
  } entry_t;

endpackage

// File: rtl/kgp_trace_ram.sv
// Trace storage: one synchronous write port, one synchronous read port, no array reset.
module kgp_trace_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 97
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/kgp_trace_buffer.sv
// Circular commit trace with PC-match trigger, post-trigger window and oldest-first readout.
module kgp_trace_buffer
  import kgp_trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] pc,
  input  logic [31:0] new_pc,
  input  logic [31:0] instruction,
  input  logic [31:0] aluresult,
  input  logic        arm,
  input  logic [31:0] trig_pc,
  input  logic        rd_en,
  output logic [2:0]  state_o,
  output logic        triggered,
  output logic        rd_valid,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_instr,
  output logic [31:0] rd_alu,
  output logic        rd_taken,
  output logic        rd_last
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] POST_LD  = ADDR_W'(POST_DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_post_cnt;
  logic [ADDR_W:0]   r_count, r_rd_num;
  logic              r_triggered, r_rd_valid, r_rd_last;

  logic              w_wr, w_rd, w_hit;
  logic [ADDR_W-1:0] w_wr_ptr_nxt, w_rd_base;
  logic [ADDR_W:0]   w_count_nxt, w_rd_num_nxt;
  entry_t            w_entry, w_rdata;

  assign w_wr = commit_valid & ~arm & ((r_state == S_RUN) | (r_state == S_POST));
  // Reads stop once every captured entry has been handed out.
  assign w_rd = rd_en & ~arm & ((r_state == S_DONE) | (r_state == S_READ)) &
                (r_rd_num != r_count);
  assign w_hit        = (pc == trig_pc);
  assign w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
  assign w_count_nxt  = (r_count == CNT_FULL) ? r_count : r_count + CNT_ONE;
  assign w_rd_num_nxt = r_rd_num + CNT_ONE;
  // Oldest entry sits at the write pointer once the ring has wrapped.
  assign w_rd_base    = (w_count_nxt == CNT_FULL) ? w_wr_ptr_nxt : '0;

  assign w_entry.pc    = pc;
  assign w_entry.instr = instruction;
  assign w_entry.alu   = aluresult;
  assign w_entry.taken = (new_pc != pc + PC_STEP);

  kgp_trace_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(ENTRY_W)) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_entry),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_rd_num    <= '0;
      r_triggered <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else if (arm) begin
      r_state     <= S_RUN;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_rd_num    <= '0;
      r_triggered <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_rd_last  <= w_rd & (w_rd_num_nxt == r_count);
      case (r_state)
        S_RUN: if (commit_valid) begin
          r_wr_ptr <= w_wr_ptr_nxt;
          r_count  <= w_count_nxt;
          if (w_hit) begin
            r_triggered <= 1'b1;
            r_post_cnt  <= POST_LD;
            if (POST_DEPTH == 0) begin
              r_state  <= S_DONE;
              r_rd_ptr <= w_rd_base;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: if (commit_valid) begin
          r_wr_ptr   <= w_wr_ptr_nxt;
          r_count    <= w_count_nxt;
          r_post_cnt <= r_post_cnt - PTR_ONE;
          if (r_post_cnt == PTR_ONE) begin
            r_state  <= S_DONE;
            r_rd_ptr <= w_rd_base;
          end
        end
        S_DONE, S_READ: if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
          r_rd_num <= w_rd_num_nxt;
          r_state  <= (w_rd_num_nxt == r_count) ? S_DONE : S_READ;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = r_state;
  assign triggered = r_triggered;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_pc     = r_rd_valid ? w_rdata.pc    : '0;
  assign rd_instr  = r_rd_valid ? w_rdata.instr : '0;
  assign rd_alu    = r_rd_valid ? w_rdata.alu   : '0;
  assign rd_taken  = r_rd_valid & w_rdata.taken;

endmodule

// File: tb/tb_kgp_trace_buffer.sv
// Scoreboard bench for kgp_trace_buffer: history-queue model, monitor pops expected reads.
module tb_kgp_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST  = 4;

  logic        clk, rst, commit_valid, arm, rd_en;
  logic [31:0] pc, new_pc, instruction, aluresult, trig_pc;
  logic [2:0]  state_o;
  logic        triggered, rd_valid, rd_taken, rd_last;
  logic [31:0] rd_pc, rd_instr, rd_alu;

  kgp_trace_buffer #(.DEPTH(DEPTH), .POST_DEPTH(POST), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .new_pc(new_pc),
    .instruction(instruction), .aluresult(aluresult), .arm(arm), .trig_pc(trig_pc),
    .rd_en(rd_en), .state_o(state_o), .triggered(triggered), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_taken(rd_taken),
    .rd_last(rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic        taken;
  } ent_t;
  typedef struct packed {
    ent_t e;
    logic last;
  } exp_t;

  ent_t hist[$];
  ent_t rlist[$];
  exp_t expq[$];
  exp_t m_x;
  bit   m_armed, m_capt, m_inpost, m_done, m_trig;
  int   m_post_left, m_rd_idx;
  int   checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_state();
    if (!m_armed) return 0;
    if (m_capt) return m_inpost ? 2 : 1;
    if (m_rd_idx > 0 && m_rd_idx < rlist.size()) return 4;
    return 3;
  endfunction

  task automatic model_arm();
    hist.delete(); rlist.delete();
    m_armed = 1; m_capt = 1; m_inpost = 0; m_done = 0; m_trig = 0; m_rd_idx = 0;
  endtask

  task automatic model_reset();
    hist.delete(); rlist.delete(); expq.delete();
    m_armed = 0; m_capt = 0; m_inpost = 0; m_done = 0; m_trig = 0; m_rd_idx = 0;
  endtask

  task automatic finish_capture();
    int n, s;
    m_capt = 0; m_inpost = 0; m_done = 1;
    n = hist.size();
    s = (n > DEPTH) ? n - DEPTH : 0;
    for (int i = s; i < n; i++) rlist.push_back(hist[i]);
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] np, input bit with_arm);
    ent_t e;
    commit_valid = 1; pc = p; new_pc = np; arm = with_arm;
    instruction = $urandom; aluresult = $urandom;
    e.pc = p; e.instr = instruction; e.alu = aluresult; e.taken = (np != p + 32'd4);
    if (with_arm) model_arm();
    else if (m_capt) begin
      hist.push_back(e);
      if (m_inpost) begin
        m_post_left--;
        if (m_post_left == 0) finish_capture();
      end else if (p == trig_pc) begin
        m_trig = 1;
        if (POST == 0) finish_capture();
        else begin m_inpost = 1; m_post_left = POST; end
      end
    end
    @(posedge clk); #1;
    commit_valid = 0; arm = 0;
  endtask

  task automatic arm_only();
    arm = 1; model_arm();
    @(posedge clk); #1;
    arm = 0;
  endtask

  task automatic read1();
    exp_t x;
    rd_en = 1;
    if (m_done && m_rd_idx < rlist.size()) begin
      x.e = rlist[m_rd_idx]; x.last = (m_rd_idx == rlist.size() - 1);
      expq.push_back(x);
      m_rd_idx++;
    end
    @(posedge clk); #1;
    rd_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(model_state()));
    chk({tag, "_triggered"}, 32'(triggered), 32'(m_trig));
  endtask

  task automatic drain(input string tag);
    idle(3);
    chk({tag, "_missing_reads"}, 32'(expq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_valid: got pc %h, required no read data at %0t", rd_pc, $time);
      end else begin
        m_x = expq.pop_front();
        chk("rd_pc", rd_pc, m_x.e.pc);
        chk("rd_instr", rd_instr, m_x.e.instr);
        chk("rd_alu", rd_alu, m_x.e.alu);
        chk("rd_taken", 32'(rd_taken), 32'(m_x.e.taken));
        chk("rd_last", 32'(rd_last), 32'(m_x.last));
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1; commit_valid = 0; arm = 0; rd_en = 0;
    pc = 0; new_pc = 0; instruction = 0; aluresult = 0; trig_pc = 0;
    model_reset();
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_pc", rd_pc, 32'd0);
    chk("rst_rd_alu", rd_alu, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Idle: commits and reads ignored before any arm
    trig_pc = 32'd0;
    commit(32'd0, 32'd4, 0);
    read1();
    drain("idle");
    status("idle");

    // Linear capture, trigger mid-stream
    trig_pc = 32'd8;
    arm_only();
    for (int i = 0; i < 7; i++) commit(32'(i * 4), 32'(i * 4 + 4), 0);
    status("lin_done");
    commit(32'd100, 32'd104, 0);
    for (int i = 0; i < 9; i++) begin read1(); if (i == 2) status("lin_read"); end
    drain("lin");
    status("lin_end");

    // Wrap: 20 commits into 16 entries
    trig_pc = 32'd60;
    arm_only();
    for (int i = 0; i < 20; i++) commit(32'(i * 4), 32'(i * 4 + 4), 0);
    status("wrap_done");
    for (int i = 0; i < 18; i++) read1();
    drain("wrap");

    // Control-flow flag, including wrap of pc + 4
    trig_pc = 32'h500;
    arm_only();
    commit(32'd100, 32'd200, 0);
    commit(32'd100, 32'd104, 0);
    commit(32'hFFFFFFFC, 32'h0, 0);
    commit(32'h500, 32'h504, 0);
    for (int i = 0; i < POST; i++) commit(32'h504 + 32'(i * 4), 32'h1234, 0);
    for (int i = 0; i < 9; i++) read1();
    drain("taken");

    // Arm coincident with a matching commit: not stored, not triggered
    trig_pc = 32'd8;
    commit(32'd8, 32'd12, 1);
    status("armcommit");
    commit(32'd8, 32'd12, 0);
    status("armcommit_post");
    for (int i = 0; i < POST; i++) commit(32'd12 + 32'(i * 4), 32'd16 + 32'(i * 4), 0);
    for (int i = 0; i < 6; i++) read1();
    drain("armcommit");

    // Reset in the middle of a readout
    trig_pc = 32'd0;
    arm_only();
    for (int i = 0; i < 5; i++) commit(32'(i * 4), 32'(i * 4 + 4), 0);
    read1(); read1();
    @(negedge clk); #1;
    rst = 1; model_reset();
    #1;
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    read1(); read1();
    drain("midrst");
    status("midrst");

    // Trigger never matches
    trig_pc = 32'hDEAD0000;
    arm_only();
    for (int i = 0; i < 30; i++) commit(32'(i * 4), 32'(i * 4 + 4), 0);
    read1(); read1(); read1();
    drain("nomatch");
    status("nomatch");

    // Randomized capture/readout rounds
    for (int r = 0; r < 25; r++) begin
      int n, nr;
      logic [31:0] p, np;
      trig_pc = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      arm_only();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        p  = ($urandom_range(0, 7) == 0) ? trig_pc : 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        np = ($urandom_range(0, 2) == 0) ? 32'($urandom) : p + 32'd4;
        commit(p, np, ($urandom_range(0, 31) == 0));
      end
      status("rnd_cap");
      nr = $urandom_range(0, 20);
      for (int i = 0; i < nr; i++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        read1();
      end
      drain("rnd");
      status("rnd_end");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kgp_trace_buffer.md
Name: kgp_trace_buffer

Overview:
- Debug trace capture stage directly downstream of the KGP-RISC core.
- Consumes the per-instruction commit outputs (pc, new_pc, instruction, aluresult).
- Records them in a circular buffer with a PC-match trigger and a post-trigger window.
- After capture, the trace is read out oldest-first through a simple request/valid handshake for bench checking or a host debug port.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 4.
- POST_DEPTH, 8, commits recorded after the trigger commit; range 0 to DEPTH-1.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- commit_valid  in  1  one cycle per committed instruction.
- pc  in  32  PC of the committing instruction.
- new_pc  in  32  next PC produced by that instruction.
- instruction  in  32  committed instruction word.
- aluresult  in  32  ALU result of that instruction.
- arm  in  1  pulse: clear the buffer and start capture.
- trig_pc  in  32  trigger PC value.
- rd_en  in  1  read request, honoured only in DONE/READ.
- state_o  out  3  current FSM state encoding.
- triggered  out  1  trigger has fired since the last arm.
- rd_valid  out  1  rd_* outputs valid this cycle.
- rd_pc  out  32  read entry: pc.
- rd_instr  out  32  read entry: instruction.
- rd_alu  out  32  read entry: aluresult.
- rd_taken  out  1  read entry: control-flow change flag.
- rd_last  out  1  asserted with rd_valid on the final entry.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; wr_ptr, rd_ptr, count, post_cnt all 0.
  - triggered=0, rd_valid=0, rd_last=0, all rd_* data 0.
  - Buffer contents are don't-care.
- Stored entry: {pc, instruction, aluresult, taken}, where taken = (new_pc != pc + 32'd4) and the add wraps modulo 2^32.
- States:
  - IDLE: nothing stored. arm -> RUN.
  - RUN: each commit_valid writes entry[wr_ptr]; wr_ptr++ wraps at DEPTH; count++ saturates at DEPTH. A commit with pc==trig_pc is stored, sets triggered=1 and loads post_cnt=POST_DEPTH. If POST_DEPTH==0 -> DONE in the same edge, otherwise -> POST.
  - POST: each commit is stored and decrements post_cnt; -> DONE on the edge that stores the commit taking post_cnt to 0. A further trig_pc match is ignored.
  - DONE: writes frozen. rd_ptr = (count==DEPTH) ? wr_ptr : 0. rd_en -> READ.
  - READ: rd_en reads entry[rd_ptr] with 1-cycle latency (rd_valid high the next cycle); rd_ptr++ wraps. rd_last asserts with the count-th entry, then the block returns to DONE with the read exhausted. Further rd_en gives rd_valid=0. rd_valid is a single-cycle pulse per accepted rd_en; back-to-back rd_en gives back-to-back data.
- Priority and boundaries:
  - arm wins over everything: from any state it resets pointers, count and triggered, clears rd_valid, and -> RUN. A commit in the same cycle as arm is NOT stored.
  - commit_valid outside RUN/POST is dropped.
  - rd_en outside DONE/READ is ignored.
  - Wrap: after more than DEPTH commits, the oldest entries are overwritten. Readout yields exactly min(commits, DEPTH) entries, oldest first.
  - Trigger on the very first commit is legal.
  - Reset mid-capture or mid-read returns to IDLE immediately; a pending rd_valid is dropped.
- triggered holds until arm or rst.

Decomposition:
- Package kgp_trace_pkg holds:
  - state encodings: IDLE=0, RUN=1, POST=2, DONE=3, READ=4;
  - the entry width constant ENTRY_W=97;
  - the PC increment constant PC_STEP=4.
- Sub-module kgp_trace_ram: DEPTH x ENTRY_W memory with one synchronous write port and one synchronous read port (1-cycle read latency), no reset on the array.
- The FSM, pointers and counters live in the top level.

Test Plan:
- Reset then arm, 5 commits with pc=0,4,8,12,16 and new_pc=pc+4, trig_pc=8, POST_DEPTH=2 -> DONE after the commit at pc=16; readout gives 5 entries pc 0..16, all rd_taken=0, rd_last on pc=16.
- 20 commits with pc=0..76, trig_pc=60, DEPTH=16, POST_DEPTH=4 -> 16 entries read: pc=16..76 oldest first, rd_last with pc=76.
- Commit pc=100, new_pc=200 vs new_pc=104 -> rd_taken 1 and 0 respectively; pc=32'hFFFFFFFC with new_pc=0 -> rd_taken=0.
- arm asserted in the same cycle as commit_valid, pc=trig_pc -> entry not stored, triggered=0, state RUN.
- rst pulsed mid-readout after 2 of 5 reads -> state_o=IDLE and rd_valid=0 within the same cycle; rd_en afterwards produces no rd_valid.
- Trigger never matches -> state stays RUN indefinitely; rd_en gives no rd_valid.
